// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (receiver now, transmitter later).
//   rx_state_e    : receiver FSM state encoding (3 bits)
//   ticks_per_bit : clocks per bit for a given clock frequency and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic int ticks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchroniser for an asynchronous level input.
// Both stages reset to 1, which matches an idle-high serial line.
//   clk, rst_n : clock, async active-low reset
//   i_async    : asynchronous input
//   o_sync     : synchronised output (second stage)
module uart_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an AXI-Stream master output.
// Each bit is sampled once near its centre using a clock-tick counter.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// the parity_err output.
//   clk, rst_n   : clock, async active-low reset
//   rx_data      : serial input, idle high, asynchronous to clk
//   axis_tdata   : received byte, stable while axis_tvalid is high
//   axis_tvalid  : byte available, held until accepted
//   axis_tready  : downstream accept
//   frame_err    : 1-cycle pulse, stop bit sampled low
//   overrun      : 1-cycle pulse, complete byte dropped because output was full
//   parity_err   : (UART_RX_PARITY_EN only) 1-cycle pulse on parity mismatch
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data,
  output logic [7:0] axis_tdata,
  output logic       axis_tvalid,
  input  logic       axis_tready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
 ,output logic       parity_err
`endif
);

  localparam int N_TICKS    = ticks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_TICKS = N_TICKS / 2;
  localparam int CNT_W      = $clog2(N_TICKS);

  logic             w_rx_s;
  logic             r_rx_prev;
  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic             w_byte_done;
  logic             w_stop_bad;
  logic             w_bit_end;
  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_frame_err;
  logic             r_overrun;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad, w_par_bad_nxt;
  logic             w_par_err;
  logic             r_parity_err;
`endif

  uart_sync_2ff u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(rx_data),
    .o_sync (w_rx_s)
  );

  assign w_bit_end = (r_cnt == CNT_W'(N_TICKS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_byte_done = 1'b0;
    w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_par_err     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = 1'b0;
`endif
        // Needs a high-to-low transition; a line stuck low never retriggers.
        if (r_rx_prev && !w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == CNT_W'(HALF_TICKS - 1)) begin
          w_cnt_nxt   = '0;
          // High at the start-bit centre means a glitch: drop it silently.
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt            = '0;
          w_shreg_nxt[r_idx]   = w_rx_s;
          w_idx_nxt            = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (r_idx == 3'd7) w_state_nxt = PARITY;
`else
          if (r_idx == 3'd7) w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STOP;
          if (w_rx_s != ^r_shreg) begin
            w_par_err     = 1'b1;
            w_par_bad_nxt = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_stop_bad  = !w_rx_s;
`ifdef UART_RX_PARITY_EN
          w_byte_done = w_rx_s && !r_par_bad;
`else
          w_byte_done = w_rx_s;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shreg     <= '0;
      r_rx_prev   <= 1'b1;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shreg     <= w_shreg_nxt;
      r_rx_prev   <= w_rx_s;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_byte_done && r_tvalid && !axis_tready;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad_nxt;
      r_parity_err <= w_par_err;
`endif
      // A new byte may replace the held one only if it is leaving this cycle.
      if (w_byte_done && (!r_tvalid || axis_tready)) begin
        r_tdata  <= r_shreg;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign axis_tdata  = r_tdata;
  assign axis_tvalid = r_tvalid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed bench for uart_rx with a queue scoreboard.
// Stimulus pushes the bytes expected on the stream; an independent monitor pops
// and compares on every handshake and counts flag pulses.
module tb_uart_rx;

  localparam int P = 217;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_data = 1'b1;
  logic       axis_tready = 1'b1;
  logic [7:0] axis_tdata;
  logic       axis_tvalid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(25_000_000), .BAUD_RATE(115200)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .axis_tdata (axis_tdata),
    .axis_tvalid(axis_tvalid),
    .axis_tready(axis_tready),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
   ,.parity_err (parity_err)
`endif
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int         obs_ferr = 0, obs_ovr = 0, obs_perr = 0;
  bit         m_slot_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame yields a byte iff stop is high (and parity good);
  // the single output slot is busy from an unaccepted byte until tready rises.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    if (!stop) exp_ferr++;
    if (PAR_EN && bad_par) exp_perr++;
    if (stop && !(PAR_EN && bad_par)) begin
      if (m_slot_full && !axis_tready) exp_ovr++;
      else begin
        exp_q.push_back(b);
        m_slot_full = !axis_tready;
      end
    end
  endtask

  task automatic bit_time(input logic v, input int per);
    rx_data = v;
    repeat (per) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop,
                            input logic bad_par);
    model_frame(b, stop, bad_par);
    bit_time(1'b0, per);
    for (int i = 0; i < 8; i++) bit_time(b[i], per);
    if (PAR_EN) bit_time((^b) ^ bad_par, per);
    bit_time(stop, per);
  endtask

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) obs_ferr++;
      if (overrun) obs_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) obs_perr++;
`endif
      if (axis_tvalid && prev_hold) check("tdata_stable", axis_tdata, prev_data);
      if (axis_tvalid && axis_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_byte: got 0x%0h expected no byte", axis_tdata);
        end else begin
          check("tdata", axis_tdata, exp_q.pop_front());
        end
      end
      prev_hold = axis_tvalid && !axis_tready;
      prev_data = axis_tdata;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stp;
    repeat (5) @(posedge clk);
    #1;
    check("rst_tdata", axis_tdata, 8'h00);
    check("rst_tvalid", axis_tvalid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // Ideal byte, always ready
    send_frame(8'h55, P, 1'b1, 1'b0);
    idle(2 * P);

    // Back-to-back with downstream stalled: second byte overruns
    axis_tready = 1'b0;
    send_frame(8'hA3, P, 1'b1, 1'b0);
    send_frame(8'h0F, P, 1'b1, 1'b0);
    idle(P);
    check("overrun_count_b2b", obs_ovr, exp_ovr);
    check("tvalid_held", axis_tvalid, 1'b1);
    check("tdata_held", axis_tdata, 8'hA3);
    axis_tready = 1'b1;
    m_slot_full = 1'b0;
    @(posedge clk);
    #1;
    check("tvalid_after_hs", axis_tvalid, 1'b0);
    idle(P);

    // Bad stop bit, then a long break, then a good byte
    send_frame(8'h81, P, 1'b0, 1'b0);
    rx_data = 1'b0;
    repeat (20 * P) @(posedge clk);
    #1;
    check("frame_err_count", obs_ferr, exp_ferr);
    idle(2 * P);
    send_frame(8'h7E, P, 1'b1, 1'b0);
    idle(2 * P);

    // Short low glitch on idle line
    rx_data = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    idle(2 * P);
    check("glitch_no_byte", exp_q.size(), 0);
    send_frame(8'h33, P, 1'b1, 1'b0);
    idle(2 * P);

    // Baud mismatch +/-2%
    send_frame(8'hC4, 213, 1'b1, 1'b0);
    idle(P);
    send_frame(8'hC4, 221, 1'b1, 1'b0);
    idle(P);

    // Reset mid-byte after bit 3
    b = 8'h5A;
    bit_time(1'b0, P);
    for (int i = 0; i < 4; i++) bit_time(b[i], P);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_tvalid", axis_tvalid, 1'b0);
    check("midrst_tdata", axis_tdata, 8'h00);
    rx_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * P);
    send_frame(8'h5A, P, 1'b1, 1'b0);
    idle(P);
    if (PAR_EN) begin
      send_frame(8'h5A, P, 1'b1, 1'b1);
      idle(P);
    end

    // Randomized frames with random gaps and occasional bad stop bits
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      stp = ($urandom_range(0, 5) != 0);
      send_frame(b, P, stp, 1'b0);
      if (!stp) idle(P + $urandom_range(10, 200));
      else idle($urandom_range(0, 300));
    end
    idle(2 * P);

    check("all_bytes_seen", exp_q.size(), 0);
    check("frame_err_total", obs_ferr, exp_ferr);
    check("overrun_total", obs_ovr, exp_ovr);
    check("parity_err_total", obs_perr, exp_perr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-AXI-Stream UART receiver.
- Sits directly downstream of the UART transmitter: it consumes the line that uart_tx drives and produces 8-bit bytes on an AXI-Stream master port.
- Frame format: 8N1, LSB first, idle-high line. Each bit is sampled once at its mid-point, timed by a clock-tick counter.
- Intended for loopback with uart_tx and for host command input.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- N_TICKS (localparam), CLK_FREQ/BAUD_RATE with integer division, clocks per bit; 217 at defaults.
- HALF_TICKS (localparam), N_TICKS/2, clocks to the mid-point of the start bit; 108 at defaults.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  1  serial line, asynchronous to clk, idle high.
- axis_tdata  output  8  received byte.
- axis_tvalid  output  1  byte available.
- axis_tready  input  1  downstream accepts byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte dropped because the output register was still full.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous assert, active-low; deassertion is expected to be externally synchronised.
- Reset values:
  - axis_tdata=0, axis_tvalid=0, frame_err=0, overrun=0.
  - Synchroniser flops=1, state=IDLE, counters=0.
- Input sync: rx_data passes through 2 flops; rx_s is the second stage. rx_prev (one more flop) supports edge detection. All decisions use rx_s.
- State machine:
  - IDLE: counter=0, bit_idx=0. On rx_prev=1 and rx_s=0 (falling edge) -> START. A line held low never retriggers without first returning high.
  - START: count to HALF_TICKS-1, then sample rx_s.
    - rx_s=0 -> DATA, counter=0.
    - rx_s=1 (glitch) -> IDLE, no output, no flags.
  - DATA: count to N_TICKS-1, then shift rx_s into shreg[bit_idx] (LSB first) and increment bit_idx. After bit 7 is sampled -> STOP.
  - STOP: count to N_TICKS-1, then sample rx_s and go to IDLE.
    - rx_s=1: byte is complete (see output rules).
    - rx_s=0: byte discarded; frame_err=1 for exactly one cycle.
- Sample timing: each sample lands at bit centre ±1 clk plus 2–3 clk synchroniser delay. Tolerated baud mismatch is ≥ ±2% at defaults.
- Latency: axis_tvalid rises on the clk edge after the stop-bit sample, about 9.5 bit times + 4 clk after the start-bit falling edge.
- Output register and handshake:
  - axis_tvalid stays high until axis_tvalid && axis_tready on a rising edge, then clears the next cycle.
  - axis_tdata is stable while axis_tvalid=1.
  - Complete byte while axis_tvalid=0: load tdata, set tvalid.
  - Complete byte while axis_tvalid=1 and axis_tready=1 in the same cycle: load new tdata, keep tvalid=1 (back-to-back, no loss).
  - Complete byte while axis_tvalid=1 and axis_tready=0: keep old byte, drop new byte, overrun=1 for one cycle.
- Back-to-back frames: the stop-bit sample lands mid-stop. IDLE is reached in time to catch the next start edge at the stop-bit end; zero gap between frames is supported.
- Reset mid-frame: immediate return to IDLE with outputs cleared. The partial byte is lost, and the next frame needs a fresh falling edge.
- Counter width: $clog2(N_TICKS) bits; the counter never exceeds N_TICKS-1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP, sampled at N_TICKS like a data bit.
  - Received parity must equal the XOR of the 8 data bits (even parity).
  - On mismatch the byte is dropped and output port parity_err (1 bit, reset 0) pulses one cycle. The stop-bit check still runs.
- Undefined: 8N1 only. No PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP; 3-bit encoding).
  - Function ticks_per_bit(clk_freq, baud).
  - Shared with a future uart_tx refactor.
- Sub-module uart_sync_2ff: 2-flop synchroniser with reset value 1, reusable for other async inputs.
- The FSM and output register stay in uart_rx.

Test Plan:
All cases use default parameters (N_TICKS=217, bit period 217 clk).
- Byte 0x55 sent ideally, tready=1 -> tvalid pulses 1 cycle with tdata=0x55; frame_err=0, overrun=0.
- Bytes 0xA3 then 0x0F back-to-back with zero gap, tready=0 until the second completes -> tdata=0xA3 held, overrun pulses once at the second stop sample; after the handshake tvalid=0.
- Byte 0x81 with stop bit forced 0 -> no tvalid, frame_err pulses one cycle. Line then held low for 20 bit times then released -> no spurious bytes. Next 0x7E received correctly.
- Low glitch of 50 clk on the idle line -> START aborts, no tvalid, no flags; a subsequent 0x33 is received correctly.
- Byte 0xC4 at baud +2% and -2% (bit period 213 and 221 clk) -> tdata=0xC4 both cases.
- rst_n pulsed low mid-byte (after bit 3), then 0x5A sent -> no output from the partial byte; tdata=0x5A. With UART_RX_PARITY_EN, 0x5A sent with wrong parity -> parity_err pulse, no tvalid.
